// File: rtl/cc_line_serializer_p_if.sv
// FIFO-pop and read-channel signals of the cache-line serializer.
// The master modport is the serializer side; the slave modport is the FIFO and the consumer.
interface cc_line_serializer_p_if #(
  parameter int LINE_W = 512,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
);
  localparam int BEATS   = LINE_W / DATA_W;
  localparam int IDX_W   = $clog2(BEATS);
  localparam int ENTRY_W = LINE_W + 2*IDX_W + 1 + ID_W;

  logic               fifo_empty_i;
  logic [ENTRY_W-1:0] fifo_rdata_i;
  logic               fifo_rden_o;
  logic [DATA_W-1:0]  rdata_o;
  logic [ID_W-1:0]    rid_o;
  logic               rlast_o;
  logic               rvalid_o;
  logic               rready_i;
  logic               busy_o;

  modport master (
    input  fifo_empty_i, fifo_rdata_i, rready_i,
    output fifo_rden_o, rdata_o, rid_o, rlast_o, rvalid_o, busy_o
  );

  modport slave (
    output fifo_empty_i, fifo_rdata_i, rready_i,
    input  fifo_rden_o, rdata_o, rid_o, rlast_o, rvalid_o, busy_o
  );
endinterface

// File: rtl/cc_line_serializer_p.sv
// Pops cache-line entries from a FWFT FIFO and streams each as a wrap or
// incrementing burst of DATA_W beats, back-to-back, with fully registered outputs.
//
// state | meaning
// IDLE  | no burst in flight, pops as soon as the FIFO has an entry
// SEND  | presenting a beat; last-beat acceptance reloads from the FIFO or returns to IDLE
module cc_line_serializer_p #(
  parameter int LINE_W = 512,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  cc_line_serializer_p_if.master  bus
);
  localparam int BEATS   = LINE_W / DATA_W;
  localparam int IDX_W   = $clog2(BEATS);
  localparam int ENTRY_W = LINE_W + 2*IDX_W + 1 + ID_W;

  typedef enum logic {IDLE, SEND} state_t;
  typedef logic [BEATS-1:0][DATA_W-1:0] line_t;

  state_t            state_q, state_d;
  line_t             line_buf_q, line_buf_d;
  logic [IDX_W-1:0]  base_q, base_d;
  logic [IDX_W-1:0]  len_eff_q, len_eff_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ID_W-1:0]   rid_q, rid_d;
  logic              rlast_q, rlast_d;
  logic              rvalid_q, rvalid_d;

  line_t             head_line;
  logic [IDX_W-1:0]  head_base, head_len, head_lim, head_len_eff, beat_idx;
  logic              head_wrap;
  logic [ID_W-1:0]   head_id;
  logic              pop, accept;

  always_comb begin
    head_line = bus.fifo_rdata_i[LINE_W-1:0];
    head_base = bus.fifo_rdata_i[LINE_W +: IDX_W];
    head_len  = bus.fifo_rdata_i[LINE_W+IDX_W +: IDX_W];
    head_wrap = bus.fifo_rdata_i[LINE_W+2*IDX_W];
    head_id   = bus.fifo_rdata_i[ENTRY_W-1 -: ID_W];
    // Incrementing bursts are clipped so they never run past the last word of the line.
    head_lim     = IDX_W'(BEATS-1) - head_base;
    head_len_eff = (head_wrap || head_len <= head_lim) ? head_len : head_lim;

    pop    = rst_n & ~bus.fifo_empty_i &
             ((state_q == IDLE) | ((state_q == SEND) & rlast_q & bus.rready_i));
    accept = rvalid_q & bus.rready_i;

    state_d    = state_q;
    line_buf_d = line_buf_q;
    base_d     = base_q;
    len_eff_d  = len_eff_q;
    cnt_d      = cnt_q;
    id_d       = id_q;
    rdata_d    = rdata_q;
    rid_d      = rid_q;
    rlast_d    = rlast_q;
    rvalid_d   = rvalid_q;
    beat_idx   = base_q + cnt_q + 1'b1;

    if (pop) begin
      state_d    = SEND;
      line_buf_d = head_line;
      base_d     = head_base;
      len_eff_d  = head_len_eff;
      cnt_d      = '0;
      id_d       = head_id;
      rdata_d    = head_line[head_base];
      rid_d      = head_id;
      rlast_d    = (head_len_eff == '0);
      rvalid_d   = 1'b1;
    end else if (accept) begin
      if (rlast_q) begin
        state_d  = IDLE;
        rdata_d  = '0;
        rid_d    = '0;
        rlast_d  = 1'b0;
        rvalid_d = 1'b0;
      end else begin
        // IDX_W-bit overflow of base+cnt gives the wrap-around for free.
        cnt_d   = cnt_q + 1'b1;
        rdata_d = line_buf_q[beat_idx];
        rlast_d = (cnt_d == len_eff_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      line_buf_q <= '0;
      base_q     <= '0;
      len_eff_q  <= '0;
      cnt_q      <= '0;
      id_q       <= '0;
      rdata_q    <= '0;
      rid_q      <= '0;
      rlast_q    <= 1'b0;
      rvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      line_buf_q <= line_buf_d;
      base_q     <= base_d;
      len_eff_q  <= len_eff_d;
      cnt_q      <= cnt_d;
      id_q       <= id_d;
      rdata_q    <= rdata_d;
      rid_q      <= rid_d;
      rlast_q    <= rlast_d;
      rvalid_q   <= rvalid_d;
    end
  end

  assign bus.fifo_rden_o = pop;
  assign bus.rdata_o     = rdata_q;
  assign bus.rid_o       = rid_q;
  assign bus.rlast_o     = rlast_q;
  assign bus.rvalid_o    = rvalid_q;
  assign bus.busy_o      = rvalid_q;
endmodule

// File: tb/tb_cc_line_serializer_p.sv
// Bench for cc_line_serializer_p: queue-based FIFO and beat-list reference model,
// directed scenarios with literal expectations, then randomized traffic with backpressure.
module tb_cc_line_serializer_p;
  localparam int LINE_W  = 512;
  localparam int DATA_W  = 64;
  localparam int ID_W    = 4;
  localparam int BEATS   = LINE_W / DATA_W;
  localparam int IDX_W   = $clog2(BEATS);
  localparam int ENTRY_W = LINE_W + 2*IDX_W + 1 + ID_W;

  typedef logic [BEATS-1:0][DATA_W-1:0] line_t;
  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [ID_W-1:0]   id;
    logic              last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cc_line_serializer_p_if #(.LINE_W(LINE_W), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();
  cc_line_serializer_p #(.LINE_W(LINE_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [ENTRY_W-1:0] fifo_q[$];
  beat_t              exp_q[$];
  logic [DATA_W-1:0]  log_d[$];
  logic [ID_W-1:0]    log_id[$];
  logic               log_last[$];
  int                 log_cyc[$];
  int                 rden_log[$];
  int                 n_chk = 0;
  int                 n_pass = 0;
  int                 cyc = 0;
  bit                 rden_at_neg = 0;
  bit                 stall_prev = 0;
  logic [DATA_W+ID_W+1:0] prev_out;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic drive_fifo();
    bus.fifo_empty_i = (fifo_q.size() == 0);
    bus.fifo_rdata_i = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  // Reference: the beats an entry must produce, derived from base/len/wrap alone.
  task automatic push_entry(input line_t line, input int base, input int len,
                            input bit wrap, input int id);
    int    le;
    beat_t b;
    le = wrap ? len : ((len < BEATS-1-base) ? len : BEATS-1-base);
    for (int k = 0; k <= le; k++) begin
      b.d    = line[(base + k) % BEATS];
      b.id   = ID_W'(id);
      b.last = (k == le);
      exp_q.push_back(b);
    end
    fifo_q.push_back({ID_W'(id), wrap, IDX_W'(len), IDX_W'(base), line});
    drive_fifo();
  endtask

  function automatic line_t seq_line(input logic [DATA_W-1:0] start);
    line_t l;
    for (int k = 0; k < BEATS; k++) l[k] = start + DATA_W'(k);
    return l;
  endfunction

  task automatic clear_logs();
    log_d.delete(); log_id.delete(); log_last.delete(); log_cyc.delete(); rden_log.delete();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rden_at_neg && fifo_q.size() != 0) void'(fifo_q.pop_front());
    drive_fifo();
  endtask

  task automatic wait_done(input string name);
    int g = 0;
    while ((exp_q.size() != 0 || bus.rvalid_o || fifo_q.size() != 0) && g < 300) begin
      step();
      g++;
    end
    chk({name, "_finished"}, 128'(g < 300), 128'(1));
  endtask

  // Compare process: every cycle, outputs against the model.
  always @(negedge clk) begin
    beat_t b;
    bit    exp_rden;
    if (!rst_n) begin
      chk("reset_outputs", 128'({bus.rvalid_o, bus.rlast_o, bus.rdata_o, bus.rid_o,
                                 bus.fifo_rden_o, bus.busy_o}), 128'(0));
      stall_prev  = 0;
      rden_at_neg = 0;
    end else begin
      exp_rden = (fifo_q.size() != 0) && (!bus.rvalid_o || (bus.rlast_o && bus.rready_i));
      chk("fifo_rden", 128'(bus.fifo_rden_o), 128'(exp_rden));
      chk("busy", 128'(bus.busy_o), 128'(bus.rvalid_o));
      if (!bus.rvalid_o)
        chk("idle_zero", 128'({bus.rdata_o, bus.rid_o, bus.rlast_o}), 128'(0));
      if (stall_prev)
        chk("stall_hold", 128'({bus.rvalid_o, bus.rlast_o, bus.rid_o, bus.rdata_o}),
            128'(prev_out));
      if (bus.rvalid_o && bus.rready_i) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", 128'({bus.rdata_o, bus.rid_o}), 128'(0));
        end else begin
          b = exp_q.pop_front();
          chk("beat", 128'({bus.rdata_o, bus.rid_o, bus.rlast_o}), 128'(b));
        end
        log_d.push_back(bus.rdata_o);
        log_id.push_back(bus.rid_o);
        log_last.push_back(bus.rlast_o);
        log_cyc.push_back(cyc);
      end
      stall_prev  = bus.rvalid_o && !bus.rready_i;
      prev_out    = {bus.rvalid_o, bus.rlast_o, bus.rid_o, bus.rdata_o};
      rden_at_neg = bus.fifo_rden_o;
      if (bus.fifo_rden_o) rden_log.push_back(cyc);
    end
  end

  logic [DATA_W-1:0] t1_exp [8];
  logic [DATA_W-1:0] t4_exp [6];
  logic [ID_W-1:0]   t4_id  [6];
  int p;
  int nlast;
  int g;

  initial begin
    t1_exp = '{64'h1005, 64'h1006, 64'h1007, 64'h1000, 64'h1001, 64'h1002, 64'h1003, 64'h1004};
    t4_exp = '{64'h1000, 64'h1001, 64'h1002, 64'h1003, 64'h1002, 64'h1003};
    t4_id  = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2};

    rst_n = 1'b0;
    bus.rready_i = 1'b0;
    drive_fifo();
    #1;
    chk("por_rvalid", 128'({bus.rvalid_o, bus.rdata_o, bus.rid_o, bus.rlast_o}), 128'(0));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // Wrap burst
    bus.rready_i = 1'b1;
    clear_logs();
    push_entry(seq_line(64'h1000), 5, 7, 1'b1, 3);
    p = cyc;
    wait_done("wrap");
    chk("wrap_count", 128'(log_d.size()), 128'(8));
    nlast = 0;
    for (int i = 0; i < log_d.size() && i < 8; i++) begin
      chk("wrap_data", 128'(log_d[i]), 128'(t1_exp[i]));
      chk("wrap_id", 128'(log_id[i]), 128'(3));
      if (log_last[i]) nlast++;
    end
    if (log_d.size() == 8) begin
      chk("wrap_last_pos", 128'(log_last[7]), 128'(1));
      chk("wrap_first_latency", 128'(log_cyc[0] - p), 128'(1));
      chk("wrap_contiguous", 128'(log_cyc[7] - log_cyc[0]), 128'(7));
    end
    chk("wrap_last_count", 128'(nlast), 128'(1));
    chk("wrap_pops", 128'(rden_log.size()), 128'(1));

    // Incrementing clamp
    clear_logs();
    push_entry(seq_line(64'h1000), 6, 7, 1'b0, 4);
    wait_done("clamp");
    chk("clamp_count", 128'(log_d.size()), 128'(2));
    if (log_d.size() == 2) begin
      chk("clamp_b0", 128'({log_d[0], log_last[0]}), 128'({64'h1006, 1'b0}));
      chk("clamp_b1", 128'({log_d[1], log_last[1]}), 128'({64'h1007, 1'b1}));
    end

    // Backpressure: beat 0 and beat 3 each stalled 2 cycles
    clear_logs();
    bus.rready_i = 1'b0;
    push_entry(seq_line(64'h1000), 5, 7, 1'b1, 3);
    p = cyc;
    for (int k = 1; k <= 14; k++) begin
      step();
      bus.rready_i = !(k == 1 || k == 2 || k == 6 || k == 7);
    end
    wait_done("stall");
    chk("stall_count", 128'(log_d.size()), 128'(8));
    if (log_d.size() == 8) begin
      chk("stall_end_cycle", 128'(log_cyc[7] - p), 128'(12));
      chk("stall_b3", 128'(log_d[3]), 128'(64'h1000));
    end

    // Back-to-back entries
    clear_logs();
    bus.rready_i = 1'b1;
    push_entry(seq_line(64'h1000), 0, 3, 1'b1, 1);
    push_entry(seq_line(64'h1000), 2, 1, 1'b0, 2);
    wait_done("b2b");
    chk("b2b_count", 128'(log_d.size()), 128'(6));
    if (log_d.size() == 6) begin
      for (int i = 0; i < 6; i++)
        chk("b2b_beat", 128'({log_d[i], log_id[i]}), 128'({t4_exp[i], t4_id[i]}));
      chk("b2b_contiguous", 128'(log_cyc[5] - log_cyc[0]), 128'(5));
    end
    chk("b2b_pops", 128'(rden_log.size()), 128'(2));
    if (rden_log.size() == 2 && log_cyc.size() == 6)
      chk("b2b_pop_at_rlast", 128'(rden_log[1]), 128'(log_cyc[3]));

    // Single beat, then idle with rready high
    clear_logs();
    push_entry(seq_line(64'h1000), 4, 0, 1'b0, 6);
    wait_done("single");
    chk("single_count", 128'(log_d.size()), 128'(1));
    if (log_d.size() == 1)
      chk("single_beat", 128'({log_d[0], log_last[0]}), 128'({64'h1004, 1'b1}));
    repeat (4) step();
    chk("idle_outputs", 128'({bus.rvalid_o, bus.rdata_o, bus.fifo_rden_o}), 128'(0));

    // Reset mid-burst
    clear_logs();
    push_entry(seq_line(64'h1000), 0, 7, 1'b1, 7);
    g = 0;
    while (log_d.size() < 3 && g < 50) begin step(); g++; end
    chk("rst_reach_beat2", 128'(log_d.size()), 128'(3));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", 128'({bus.rvalid_o, bus.rlast_o, bus.rdata_o, bus.rid_o}), 128'(0));
    exp_q.delete();
    fifo_q.delete();
    clear_logs();
    push_entry(seq_line(64'h2000), 2, 3, 1'b1, 5);
    #1;
    chk("rst_no_pop", 128'(bus.fifo_rden_o), 128'(0));
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    wait_done("post_rst");
    chk("post_rst_count", 128'(log_d.size()), 128'(4));
    if (log_d.size() == 4)
      chk("post_rst_first", 128'({log_d[0], log_id[0]}), 128'({64'h2002, 4'd5}));

    // Randomized traffic with random backpressure
    for (int i = 0; i < 3000; i++) begin
      step();
      bus.rready_i = ($urandom_range(0, 3) != 0);
      if (fifo_q.size() < 3 && $urandom_range(0, 2) == 0) begin
        line_t l;
        for (int k = 0; k < BEATS; k++) l[k] = {$urandom, $urandom};
        push_entry(l, int'($urandom_range(0, BEATS-1)), int'($urandom_range(0, BEATS-1)),
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
      end
    end
    bus.rready_i = 1'b1;
    wait_done("random");
    chk("random_drained", 128'(exp_q.size()), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cc_line_serializer_p.md
Name: cc_line_serializer_p

Overview:
- Parametrised successor of the cache-controller read-path serializer.
- Pops one cache-line entry from a first-word-fall-through FIFO and emits it as a burst of DATA_W beats on a valid/ready read channel.
- Per-entry start word, burst length, wrap/incrementing mode and transaction ID.
- Output is fully registered; consecutive entries stream back-to-back with no idle cycle between bursts.

Parameters:
- LINE_W, 512, cache line width in bits; must be a multiple of DATA_W.
- DATA_W, 64, beat width in bits.
- ID_W, 4, transaction ID width.
- BEATS, LINE_W/DATA_W (derived), beats per line; power of two, at least 2.
- IDX_W, $clog2(BEATS) (derived), word-index width.
- ENTRY_W, LINE_W+2*IDX_W+1+ID_W (derived), FIFO entry width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- fifo_empty_i  in  1  FIFO empty
- fifo_rdata_i  in  ENTRY_W  FWFT head entry, see layout below
- fifo_rden_o  out  1  pop strobe; head consumed on this cycle's clk edge
- rdata_o  out  DATA_W  beat data
- rid_o  out  ID_W  beat ID
- rlast_o  out  1  last beat of burst
- rvalid_o  out  1  beat valid
- rready_i  in  1  downstream ready
- busy_o  out  1  burst in progress (equal to rvalid_o)

Behaviour:
- Entry layout, LSB first:
  - line [LINE_W-1:0]
  - base word [LINE_W +: IDX_W]
  - len = beats-1 [LINE_W+IDX_W +: IDX_W]
  - wrap [LINE_W+2*IDX_W]
  - id [ENTRY_W-1 -: ID_W]
- Reset (asynchronous, any cycle including mid-burst):
  - state IDLE; all buffers and the beat counter cleared.
  - rvalid_o=0, rlast_o=0, rdata_o=0, rid_o=0, fifo_rden_o=0.
  - The partial burst is dropped and is not resumed.
- States: IDLE, SEND.
- Pop rule: fifo_rden_o = ~fifo_empty_i & (IDLE | (SEND & rlast_o & rready_i)).
  - On a pop: capture line, base, len, wrap and id into buffers; clear the counter; next state is SEND.
- IDLE -> SEND on a pop. Latency: entry visible at the FIFO head in cycle N gives rvalid_o=1 in cycle N+1. No combinational path from the FIFO to rvalid_o or rdata_o.
- SEND, beat accepted (rvalid_o & rready_i):
  - not last: counter increments.
  - last, FIFO not empty: pop and reload; stay in SEND; next cycle carries beat 0 of the new burst (zero bubble).
  - last, FIFO empty: go to IDLE.
- SEND with rready_i=0: rdata_o, rid_o, rlast_o and rvalid_o hold stable until accepted.
- Effective length len_eff:
  - wrap=1: len_eff = len.
  - wrap=0: len_eff = min(len, BEATS-1-base). The burst never runs past the line end; clamping is silent.
- Word index:
  - wrap=1: (base + cnt) mod BEATS, using IDX_W-bit natural overflow.
  - wrap=0: base + cnt, which never exceeds BEATS-1.
- Outputs:
  - rdata_o = line_buf[word_idx*DATA_W +: DATA_W] when rvalid_o, else 0.
  - rid_o = id_buf when rvalid_o, else 0.
  - rlast_o = SEND & (cnt == len_eff).
- len=0 gives a single beat with rlast_o asserted on that beat.
- fifo_empty_i rising mid-burst has no effect on the current burst.
- rready_i high while IDLE is ignored.

Test Plan:
- Wrap burst: line words Wk = 64'h1000+k, base=5, len=7, wrap=1, id=3, rready_i=1. Expect beats 1005,1006,1007,1000..1004 in 8 consecutive cycles, rid_o=3, rlast_o only on 1004, one fifo_rden_o pulse, rvalid_o first high one cycle after the entry appears.
- Incrementing clamp: base=6, len=7, wrap=0. Expect exactly 2 beats (1006, 1007) with rlast_o on 1007, then IDLE.
- Backpressure: wrap burst with rready_i low on beats 0 and 3 for 2 cycles each. Expect data, rid_o and rlast_o held stable while stalled, 8 beats total, burst finishing 4 cycles later than unstalled.
- Back-to-back: two entries queued (id=1 base=0 len=3 wrap=1; id=2 base=2 len=1 wrap=0). Expect 6 contiguous valid cycles: 1000..1003 with id 1, then 1002..1003 with id 2. Second pop coincides with acceptance of the first rlast_o; no bubble.
- Single beat and idle: len=0, base=4. Expect one beat 1004 with rlast_o=1. Then with fifo_empty_i held high, expect rvalid_o=0, rdata_o=0, fifo_rden_o=0.
- Reset mid-burst: assert rst_n=0 asynchronously after beat 2 of an 8-beat burst. Expect all outputs at 0 immediately, without waiting for a clock edge. After release with a new entry queued, expect its beat 0 and no remnant of the old burst.
